program_memory_arbiter: RTL
===========================

Name: program_memory_arbiter

Overview:
Shares the single combinational program ROM between two requesters: port 0 is instruction fetch and port 1 is the debug/loader readback. It uses a 3-state FSM: grant, drive the ROM address for one cycle, then return the registered instruction with a one-cycle valid pulse. It also checks that the byte address falls inside the text segment and is word-aligned, and flags an error if not. It sits between the fetch/debug logic and the program memory instance.

Parameters:
MEMORY_DEPTH, 32, number of 32-bit words in the program ROM
DATA_WIDTH, 32, address and instruction width
BASE_ADDR, 32'h0040_0000, byte address of ROM word 0 (text segment base)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_i  input  1  port 0 (fetch) request; held high until valid0_o
addr0_i  input  DATA_WIDTH  port 0 byte address; stable while req0_i is high
req1_i  input  1  port 1 (debug) request; held high until valid1_o
addr1_i  input  DATA_WIDTH  port 1 byte address
gnt0_o / gnt1_o  output  1 each  port owns the ROM this cycle (ACCESS state)
valid0_o / valid1_o  output  1 each  one-cycle response strobe
data0_o / data1_o  output  DATA_WIDTH each  returned instruction; held until that port's next response
err0_o / err1_o  output  1 each  response error; qualified by the matching valid
mem_address_o  output  DATA_WIDTH  byte address to the program memory address_i
mem_instruction_i  input  DATA_WIDTH  combinational program memory instruction_o

Behaviour:
- Reset values: state=IDLE; all gnt, valid and err outputs = 0; data0_o = data1_o = 0; mem_address_o = BASE_ADDR; the last-served pointer points at port 1, so port 0 wins the first tie.
- Reset asserted mid-operation: the in-flight access is dropped, no valid is issued, and the FSM is in IDLE when reset releases.
- IDLE:
  - If any request is high, latch the winner's id and address at the clock edge and go to ACCESS.
  - If no request is high, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gnt for the owner is high.
  - mem_address_o = latched address.
  - At the clock edge, capture mem_instruction_i into the owner's data register and the range/alignment check into its err flag, then go to RESP.
- RESP (exactly 1 cycle):
  - valid for the owner is high, with data and err.
  - Requests are ignored in this cycle. The requester drops req, or presents a new address, in this cycle.
  - Go to IDLE.
- Latency: request seen in IDLE at edge k, gnt high in cycle k+1, valid high in cycle k+2. Throughput is one access per 3 cycles.
- Error condition: (addr - BASE_ADDR) >= 4*MEMORY_DEPTH, OR addr < BASE_ADDR, OR addr[1:0] != 0.
  - On error, the returned data is 32'h0000_0000 (NOP) and err is 1.
  - On error the ROM is still addressed with BASE_ADDR, never with the bad address.
- Subtraction is unsigned, modulo 2^DATA_WIDTH; the explicit addr < BASE_ADDR term catches wrap-around.
- Both requests high in IDLE: the winner is chosen by the arbitration policy (see Optional Feature).
- Only one of gnt0_o/gnt1_o is ever high; only one of valid0_o/valid1_o is ever high.
- The non-owner's data and err registers are unchanged by an access.

Optional Feature:
Macro: ARBITER_ROUND_ROBIN_EN
- Defined: round-robin. On a tie, the port not served last wins. The last-served pointer updates on entry to ACCESS.
- Undefined: fixed priority, port 0 (fetch) always wins ties. The pointer logic is absent. Port 1 is served only when req0_i is low in IDLE.

Test Plan:
- Reset then req0_i=1, addr0_i=32'h0040_0008, ROM word 2=32'h2009_0005 -> gnt0_o in cycle 1, valid0_o in cycle 2 with data0_o=32'h2009_0005, err0_o=0, mem_address_o=32'h0040_0008 during ACCESS.
- Out of range, req1_i with addr1_i=32'h0040_0080 (DEPTH 32) -> valid1_o with err1_o=1, data1_o=0; mem_address_o never shows 32'h0040_0080.
- Misaligned, addr0_i=32'h0040_0006 -> err0_o=1, data0_o=0. Below base, addr0_i=32'h003F_FFFC -> err0_o=1.
- Both requests held continuously, 4 accesses:
  - Macro undefined -> four port-0 responses, no valid1_o.
  - Macro defined -> grants alternate 0,1,0,1.
- Reset asserted during ACCESS -> no valid0_o/valid1_o afterwards, outputs at reset values; a new request after release completes with normal 2-cycle latency.
- Port 1 response followed by port 0 response -> data1_o keeps the earlier value while data0_o updates.

Source files
------------

// File: rtl/program_memory_arbiter_if.sv
// ---------------------------------------------------------------------------
// program_memory_arbiter_if
// Bundles the two requester ports and the program-memory side of the
// program memory arbiter.
//   req0_i/addr0_i, req1_i/addr1_i : fetch (0) and debug (1) requests
//   gnt*_o, valid*_o, data*_o, err*_o : per-port grant and response
//   mem_address_o / mem_instruction_i : combinational program ROM port
// Modports:
//   slave  - the arbiter itself
//   master - requesters and program memory (the environment around it)
// ---------------------------------------------------------------------------
interface program_memory_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0_i;
  logic [DATA_WIDTH-1:0] addr0_i;
  logic                  req1_i;
  logic [DATA_WIDTH-1:0] addr1_i;
  logic                  gnt0_o;
  logic                  gnt1_o;
  logic                  valid0_o;
  logic                  valid1_o;
  logic [DATA_WIDTH-1:0] data0_o;
  logic [DATA_WIDTH-1:0] data1_o;
  logic                  err0_o;
  logic                  err1_o;
  logic [DATA_WIDTH-1:0] mem_address_o;
  logic [DATA_WIDTH-1:0] mem_instruction_i;

  modport slave (
    input  req0_i, addr0_i, req1_i, addr1_i, mem_instruction_i,
    output gnt0_o, gnt1_o, valid0_o, valid1_o,
    output data0_o, data1_o, err0_o, err1_o, mem_address_o
  );

  modport master (
    output req0_i, addr0_i, req1_i, addr1_i, mem_instruction_i,
    input  gnt0_o, gnt1_o, valid0_o, valid1_o,
    input  data0_o, data1_o, err0_o, err1_o, mem_address_o
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// program_memory_arbiter
// Shares one combinational program ROM between instruction fetch (port 0)
// and debug/loader readback (port 1). Each access takes three cycles:
// IDLE (arbitrate and latch), ACCESS (drive ROM address, grant high),
// RESP (one-cycle valid pulse with data and error flag).
// Addresses outside the text segment or not word-aligned return a NOP
// (all zeros) with the error flag set; the ROM then sees BASE_ADDR.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - program_memory_arbiter_if.slave (requests, responses, ROM port)
//
// Configuration macro:
//   ARBITER_ROUND_ROBIN_EN - defined: round-robin tie break with a
//                            last-served pointer; undefined: port 0 always
//                            wins ties (fixed priority).
// ---------------------------------------------------------------------------
module program_memory_arbiter #(
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
  input logic                      clk,
  input logic                      reset,
  program_memory_arbiter_if.slave  bus
);

  // Size of the text segment in bytes.
  localparam logic [DATA_WIDTH-1:0] L_SPAN = DATA_WIDTH'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_owner;      // 1: port 1 owns the current access
  logic                  r_addr_err;   // range/alignment check of latched address
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_valid0;
  logic                  r_valid1;
  logic [DATA_WIDTH-1:0] r_data0;
  logic [DATA_WIDTH-1:0] r_data1;
  logic                  r_err0;
  logic                  r_err1;
`ifdef ARBITER_ROUND_ROBIN_EN
  logic                  r_last1;      // 1: port 1 was served last
`endif

  logic                  w_any_req;
  logic                  w_pick1;
  logic [DATA_WIDTH-1:0] w_req_addr;
  logic                  w_req_err;

  // The wrap-around of the unsigned offset is caught by the explicit
  // below-base term.
  function automatic logic addr_error(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] offset;
    offset = addr - BASE_ADDR;
    return (offset >= L_SPAN) || (addr < BASE_ADDR) || (addr[1:0] != 2'b00);
  endfunction

  // Arbitration winner and the address/check of the winning request.
  always_comb begin
    w_any_req = bus.req0_i || bus.req1_i;
`ifdef ARBITER_ROUND_ROBIN_EN
    // On a tie, the port not served last wins.
    w_pick1 = bus.req1_i && (!bus.req0_i || !r_last1);
`else
    w_pick1 = bus.req1_i && !bus.req0_i;
`endif
    if (w_pick1) begin
      w_req_addr = bus.addr1_i;
    end else begin
      w_req_addr = bus.addr0_i;
    end
    w_req_err = addr_error(w_req_addr);
  end

  // Access FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_addr_err <= 1'b0;
      r_mem_addr <= BASE_ADDR;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_data0    <= '0;
      r_data1    <= '0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      r_last1    <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid0 <= 1'b0;
          r_valid1 <= 1'b0;
          if (w_any_req) begin
            r_owner    <= w_pick1;
            r_addr_err <= w_req_err;
            // A bad address never reaches the ROM.
            r_mem_addr <= w_req_err ? BASE_ADDR : w_req_addr;
            r_gnt0     <= !w_pick1;
            r_gnt1     <= w_pick1;
`ifdef ARBITER_ROUND_ROBIN_EN
            r_last1    <= w_pick1;
`endif
            r_state    <= S_ACCESS;
          end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          // Only the owner's data/err registers change.
          if (r_owner) begin
            r_data1  <= r_addr_err ? '0 : bus.mem_instruction_i;
            r_err1   <= r_addr_err;
            r_valid1 <= 1'b1;
            r_valid0 <= 1'b0;
          end else begin
            r_data0  <= r_addr_err ? '0 : bus.mem_instruction_i;
            r_err0   <= r_addr_err;
            r_valid0 <= 1'b1;
            r_valid1 <= 1'b0;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          // Requests are ignored here; the requester updates req/addr now.
          r_valid0 <= 1'b0;
          r_valid1 <= 1'b0;
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_valid0 <= 1'b0;
          r_valid1 <= 1'b0;
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0_o        = r_gnt0;
  assign bus.gnt1_o        = r_gnt1;
  assign bus.valid0_o      = r_valid0;
  assign bus.valid1_o      = r_valid1;
  assign bus.data0_o       = r_data0;
  assign bus.data1_o       = r_data1;
  assign bus.err0_o        = r_err0;
  assign bus.err1_o        = r_err1;
  assign bus.mem_address_o = r_mem_addr;

endmodule
